// File: rtl/deserializer_1to32_sync.sv
// ---------------------------------------------------------------------------
// deserializer_1to32_sync
//
// Purpose:
//   Receive-side partner of the 32-to-1 serializer. Gathers an MSB-first
//   serial stream into 32-bit words, hunts bit-by-bit for SYNC_WORD, then
//   emits FRAME_WORDS data words per frame before re-checking the sync word.
//   Up to MAX_MISS-1 consecutive bad sync words are tolerated (flywheel)
//   before lock is dropped and the hunt restarts.
//
// Ports:
//   clk          in   1   system clock, rising edge
//   reset        in   1   synchronous, active-high reset
//   data_in      in   1   serial data, MSB of each word first
//   in_valid     in   1   data_in carries a valid bit this cycle
//   data_out     out  32  last captured data word, held until next capture
//   data_valid   out  1   one-cycle pulse when data_out is updated
//   locked       out  1   high while in DATA or CHECK
//   sync_err     out  1   one-cycle pulse per sync-word mismatch in CHECK
//   frame_start  out  1   one-cycle pulse when a sync word is accepted
// ---------------------------------------------------------------------------
module deserializer_1to32_sync #(
   parameter logic [31:0] SYNC_WORD   = 32'hA5C3_0F1E,
   parameter int          FRAME_WORDS = 4,
   parameter int          MAX_MISS    = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        data_in,
   input  logic        in_valid,
   output logic [31:0] data_out,
   output logic        data_valid,
   output logic        locked,
   output logic        sync_err,
   output logic        frame_start
);

   localparam logic [7:0] LP_FRAME_WORDS = 8'(FRAME_WORDS);
   localparam logic [3:0] LP_MAX_MISS    = 4'(MAX_MISS);

   typedef enum logic [1:0] {
      ST_HUNT  = 2'd0,
      ST_DATA  = 2'd1,
      ST_CHECK = 2'd2
   } state_t;

   state_t      r_state;
   logic [31:0] r_sr;
   logic [4:0]  r_bit_cnt;
   logic [7:0]  r_word_cnt;
   logic [3:0]  r_miss_cnt;
   logic [31:0] r_data_out;
   logic        r_data_valid;
   logic        r_locked;
   logic        r_sync_err;
   logic        r_frame_start;

   // Shift register contents as they will be after this cycle's bit.
   logic [31:0] w_nxt;
   logic        w_sync_hit;
   logic        w_last_bit;

   assign w_nxt      = {r_sr[30:0], data_in};
   assign w_sync_hit = (w_nxt == SYNC_WORD);
   assign w_last_bit = (r_bit_cnt == 5'd31);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= ST_HUNT;
         r_sr          <= '0;
         r_bit_cnt     <= '0;
         r_word_cnt    <= '0;
         r_miss_cnt    <= '0;
         r_data_out    <= '0;
         r_data_valid  <= 1'b0;
         r_locked      <= 1'b0;
         r_sync_err    <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         // Pulses default low; only a valid bit can raise one.
         r_data_valid  <= 1'b0;
         r_sync_err    <= 1'b0;
         r_frame_start <= 1'b0;

         if (in_valid) begin
            r_sr <= w_nxt;

            case (r_state)
               ST_HUNT: begin
                  // Compare on every bit so any alignment offset is found.
                  if (w_sync_hit) begin
                     r_state       <= ST_DATA;
                     r_bit_cnt     <= '0;
                     r_word_cnt    <= '0;
                     r_miss_cnt    <= '0;
                     r_frame_start <= 1'b1;
                     r_locked      <= 1'b1;
                  end
               end

               ST_DATA: begin
                  if (w_last_bit) begin
                     r_data_out   <= w_nxt;
                     r_data_valid <= 1'b1;
                     r_bit_cnt    <= '0;
                     if (r_word_cnt + 8'd1 == LP_FRAME_WORDS) begin
                        r_word_cnt <= '0;
                        r_state    <= ST_CHECK;
                     end else begin
                        r_word_cnt <= r_word_cnt + 8'd1;
                     end
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 5'd1;
                  end
               end

               ST_CHECK: begin
                  if (w_last_bit) begin
                     r_bit_cnt  <= '0;
                     r_word_cnt <= '0;
                     if (w_sync_hit) begin
                        r_miss_cnt    <= '0;
                        r_frame_start <= 1'b1;
                        r_state       <= ST_DATA;
                     end else begin
                        r_sync_err <= 1'b1;
                        if (r_miss_cnt + 4'd1 == LP_MAX_MISS) begin
                           r_state    <= ST_HUNT;
                           r_locked   <= 1'b0;
                           r_miss_cnt <= '0;
                        end else begin
                           // Flywheel: keep alignment and carry on with data.
                           r_miss_cnt <= r_miss_cnt + 4'd1;
                           r_state    <= ST_DATA;
                        end
                     end
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 5'd1;
                  end
               end

               default: begin
                  r_state  <= ST_HUNT;
                  r_locked <= 1'b0;
               end
            endcase
         end
      end
   end

   assign data_out    = r_data_out;
   assign data_valid  = r_data_valid;
   assign locked      = r_locked;
   assign sync_err    = r_sync_err;
   assign frame_start = r_frame_start;

endmodule

// File: tb/tb_deserializer_1to32_sync.sv
module tb_deserializer_1to32_sync;

   localparam logic [31:0] SYNC = 32'hA5C3_0F1E;
   localparam logic [31:0] W0   = 32'h0000_0001;
   localparam logic [31:0] W1   = 32'hDEAD_BEEF;
   localparam logic [31:0] W2   = 32'hFFFF_FFFF;
   localparam logic [31:0] W3   = 32'h8000_0000;

   logic        clk;
   logic        reset;
   logic        data_in;
   logic        in_valid;
   logic [31:0] data_out;
   logic        data_valid;
   logic        locked;
   logic        sync_err;
   logic        frame_start;

   int          checks;
   int          failures;
   int          n_dv;
   int          n_fs;
   int          n_err;
   logic [31:0] got [$];
   logic [31:0] exp_words [4];

   deserializer_1to32_sync dut (
      .clk         (clk),
      .reset       (reset),
      .data_in     (data_in),
      .in_valid    (in_valid),
      .data_out    (data_out),
      .data_valid  (data_valid),
      .locked      (locked),
      .sync_err    (sync_err),
      .frame_start (frame_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic clear_counts();
      n_dv  = 0;
      n_fs  = 0;
      n_err = 0;
      got.delete();
   endtask

   // Drive one cycle, then observe outputs 1 time unit after the edge.
   task automatic tick(input logic b, input logic v);
      data_in  = b;
      in_valid = v;
      @(posedge clk);
      #1;
      if (data_valid === 1'b1) begin
         n_dv++;
         got.push_back(data_out);
      end
      if (frame_start === 1'b1) n_fs++;
      if (sync_err === 1'b1) n_err++;
      if (!v && !reset)
         check("idle_no_pulse", {29'd0, data_valid, frame_start, sync_err}, 32'd0);
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      for (int i = 31; i >= 0; i--) begin
         tick(w[i], 1'b1);
         repeat (gap) tick(1'b1, 1'b0);
      end
   endtask

   task automatic send_frame(input int gap);
      for (int k = 0; k < 4; k++) send_word(exp_words[k], gap);
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      in_valid = 1'b0;
      data_in  = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic check_words(input string tag);
      check({tag, "_count"}, 32'(n_dv), 32'd4);
      for (int k = 0; k < 4; k++)
         check({tag, "_word"}, (got.size() > k) ? got[k] : 32'hxxxx_xxxx, exp_words[k]);
   endtask

   initial begin
      logic [6:0] pre;
      checks    = 0;
      failures  = 0;
      reset     = 1'b1;
      data_in   = 1'b0;
      in_valid  = 1'b0;
      exp_words[0] = W0;
      exp_words[1] = W1;
      exp_words[2] = W2;
      exp_words[3] = W3;
      clear_counts();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // ---- reset state ----
      check("rst_data_out", data_out, 32'd0);
      check("rst_pulses", {29'd0, data_valid, frame_start, sync_err}, 32'd0);
      check("rst_locked", {31'd0, locked}, 32'd0);

      // ---- 1: clean frame ----
      do_reset();
      clear_counts();
      for (int i = 31; i >= 1; i--) tick(SYNC[i], 1'b1);
      check("s1_locked_pre", {31'd0, locked}, 32'd0);
      tick(SYNC[0], 1'b1);
      check("s1_frame_start", {31'd0, frame_start}, 32'd1);
      check("s1_locked_post", {31'd0, locked}, 32'd1);
      send_word(W0, 0);
      check("s1_latency_dv", {31'd0, data_valid}, 32'd1);
      check("s1_latency_dout", data_out, W0);
      send_word(W1, 0);
      send_word(W2, 0);
      send_word(W3, 0);
      check_words("s1");
      check("s1_fs_count", 32'(n_fs), 32'd1);

      // ---- 2: lock at bit offset 7 ----
      do_reset();
      clear_counts();
      pre = 7'b1011001;
      for (int i = 6; i >= 0; i--) tick(pre[i], 1'b1);
      send_word(SYNC, 0);
      send_frame(0);
      check_words("s2");
      check("s2_fs_count", 32'(n_fs), 32'd1);

      // ---- 3: flywheel then loss of lock ----
      do_reset();
      send_word(SYNC, 0);
      send_frame(0);
      clear_counts();
      send_word(32'h0, 0);
      check("s3_err1", 32'(n_err), 32'd1);
      check("s3_locked_fly", {31'd0, locked}, 32'd1);
      send_frame(0);
      check_words("s3_fly");
      clear_counts();
      send_word(32'h0, 0);
      check("s3_err2", 32'(n_err), 32'd1);
      check("s3_locked_lost", {31'd0, locked}, 32'd0);
      clear_counts();
      send_frame(0);
      check("s3_hunt_no_dv", 32'(n_dv), 32'd0);
      check("s3_hunt_hold", data_out, W3);
      send_word(SYNC, 0);
      check("s3_relock_fs", 32'(n_fs), 32'd1);
      send_word(W1, 0);
      check("s3_relock_word", data_out, W1);

      // ---- 4: in_valid pattern 1,0,0 repeating ----
      do_reset();
      clear_counts();
      send_word(SYNC, 2);
      send_frame(2);
      check_words("s4");
      check("s4_fs_count", 32'(n_fs), 32'd1);

      // ---- 5: reset mid-word ----
      do_reset();
      send_word(SYNC, 0);
      send_word(W0, 0);
      for (int i = 31; i >= 12; i--) tick(W1[i], 1'b1);
      reset = 1'b1;
      tick(1'b1, 1'b1);
      reset = 1'b0;
      check("s5_rst_dout", data_out, 32'd0);
      check("s5_rst_pulses", {29'd0, data_valid, frame_start, sync_err}, 32'd0);
      check("s5_rst_locked", {31'd0, locked}, 32'd0);
      clear_counts();
      send_word(SYNC, 0);
      send_frame(0);
      check_words("s5");

      // ---- 6: serializer loopback, one load gap per word ----
      do_reset();
      clear_counts();
      tick(1'b1, 1'b0);
      send_word(SYNC, 0);
      for (int k = 0; k < 4; k++) begin
         tick(1'b1, 1'b0);
         send_word(exp_words[k], 0);
      end
      check_words("s6");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
